// File: rtl/traffic_light_ctrl.sv
// Two-direction intersection controller: timed green/yellow/all-red cycle,
// pedestrian shortening of the green, and a flashing-yellow night mode.
module traffic_light_ctrl #(
    parameter int unsigned T_GREEN  = 25,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_PED    = 5,
    parameter int unsigned CNT_W    = 7
) (
    input  logic             clockIn,
    input  logic             rst,
    input  logic             tick,
    input  logic             night,
    input  logic             ped_req,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [CNT_W-1:0] remain,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED1  = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED2  = 3'd5,
        NIGHT = 3'd6
    } phase_e;

    typedef struct packed {
        phase_e           ph;
        logic [CNT_W-1:0] remain;
        logic             pedPend;
        logic             blink;
    } ctrl_t;

    localparam logic [CNT_W-1:0] LEN_G  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] LEN_Y  = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] LEN_AR = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] LEN_P  = CNT_W'(T_PED);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    ctrl_t  cur, nxt;
    phase_e nextPh;
    logic   advance;
    logic   pedAny;
    logic   lastTick;

    function automatic logic [CNT_W-1:0] phaseLen(input phase_e p);
        case (p)
            NS_G, EW_G: phaseLen = LEN_G;
            NS_Y, EW_Y: phaseLen = LEN_Y;
            RED1, RED2: phaseLen = LEN_AR;
            default:    phaseLen = '0;
        endcase
    endfunction

    always_ff @(posedge clockIn) begin
        if (rst) begin
            cur.ph      <= RED2;
            cur.remain  <= LEN_AR;
            cur.pedPend <= 1'b0;
            cur.blink   <= 1'b0;
        end else begin
            cur <= nxt;
        end
    end

    assign pedAny   = cur.pedPend | ped_req;
    assign lastTick = tick && (cur.remain == ONE);

    // Each state only decides whether to advance and where; the entry
    // loads (duration, pedestrian clear, blink seed) are shared below.
    always_comb begin
        nxt         = cur;
        nxt.pedPend = pedAny;
        advance     = 1'b0;
        nextPh      = cur.ph;

        case (cur.ph)
            NS_G, EW_G: begin
                if (tick) begin
                    if (night || cur.remain == ONE) begin
                        advance = 1'b1;
                        nextPh  = (cur.ph == NS_G) ? NS_Y : EW_Y;
                    end else if (pedAny && cur.remain > LEN_P) begin
                        nxt.remain = LEN_P;
                    end else begin
                        nxt.remain = cur.remain - ONE;
                    end
                end
            end
            NS_Y: begin
                if (lastTick) begin
                    advance = 1'b1;
                    nextPh  = RED1;
                end else if (tick) begin
                    nxt.remain = cur.remain - ONE;
                end
            end
            EW_Y: begin
                if (lastTick) begin
                    advance = 1'b1;
                    nextPh  = RED2;
                end else if (tick) begin
                    nxt.remain = cur.remain - ONE;
                end
            end
            RED1: begin
                if (lastTick) begin
                    advance = 1'b1;
                    nextPh  = night ? NIGHT : EW_G;
                end else if (tick) begin
                    nxt.remain = cur.remain - ONE;
                end
            end
            RED2: begin
                if (lastTick) begin
                    advance = 1'b1;
                    nextPh  = night ? NIGHT : NS_G;
                end else if (tick) begin
                    nxt.remain = cur.remain - ONE;
                end
            end
            NIGHT: begin
                nxt.remain = '0;
                if (tick) begin
                    if (!night) begin
                        advance = 1'b1;
                        nextPh  = RED2;
                    end else begin
                        nxt.blink = ~cur.blink;
                    end
                end
            end
            default: begin
                // Corrupted encoding: recover into the all-red clearance.
                advance   = 1'b1;
                nextPh    = RED2;
                nxt.blink = 1'b0;
            end
        endcase

        if (advance) begin
            nxt.ph     = nextPh;
            nxt.remain = phaseLen(nextPh);
            if (nextPh == RED1 || nextPh == RED2)
                nxt.pedPend = 1'b0;
            if (nextPh == NIGHT)
                nxt.blink = 1'b1;
        end
    end

    always_comb begin
        ns_light = L_RED;
        ew_light = L_RED;
        case (cur.ph)
            NS_G:  ns_light = L_GRN;
            NS_Y:  ns_light = L_YEL;
            EW_G:  ew_light = L_GRN;
            EW_Y:  ew_light = L_YEL;
            NIGHT: begin
                ns_light = {1'b0, cur.blink, 1'b0};
                ew_light = {1'b0, cur.blink, 1'b0};
            end
            default: ;
        endcase
    end

    assign remain = cur.remain;
    assign phase  = cur.ph;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed and randomized checks of traffic_light_ctrl against a table-driven
// phase model; a per-cycle monitor guards against conflicting lights.
module tb_traffic_light_ctrl;

    localparam int T_GREEN  = 4;
    localparam int T_YELLOW = 2;
    localparam int T_ALLRED = 1;
    localparam int T_PED    = 2;
    localparam int CNT_W    = 7;

    logic             clockIn = 1'b0;
    logic             rst = 1'b0, tick = 1'b0, night = 1'b0, ped_req = 1'b0;
    logic [2:0]       ns_light, ew_light;
    logic [CNT_W-1:0] remain;
    logic [2:0]       phase;

    int vectors = 0;
    int errs    = 0;
    bit armed   = 0;

    traffic_light_ctrl #(
        .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED),
        .T_PED(T_PED), .CNT_W(CNT_W)
    ) dut (
        .clockIn(clockIn), .rst(rst), .tick(tick), .night(night),
        .ped_req(ped_req), .ns_light(ns_light), .ew_light(ew_light),
        .remain(remain), .phase(phase)
    );

    always #5 clockIn = ~clockIn;

    // Reference model: phase index 0..5 is the ring, 6 is night.
    int mPh, mRem;
    bit mPend, mBlink;

    function automatic int dur(input int p);
        int d [7] = '{T_GREEN, T_YELLOW, T_ALLRED, T_GREEN, T_YELLOW, T_ALLRED, 0};
        return d[p];
    endfunction

    function automatic logic [5:0] lightsOf(input int p, input bit b);
        logic [5:0] t [6] = '{6'b001_100, 6'b010_100, 6'b100_100,
                              6'b100_001, 6'b100_010, 6'b100_100};
        if (p == 6) return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
        return t[p];
    endfunction

    task automatic enterPh(input int p);
        mPh  = p;
        mRem = dur(p);
        if (p == 2 || p == 5) mPend = 0;
        if (p == 6) mBlink = 1;
    endtask

    task automatic modelStep(input bit r, input bit t, input bit n, input bit p);
        bit pendAny, green;
        if (r) begin
            mPh = 5; mRem = T_ALLRED; mPend = 0; mBlink = 0;
            return;
        end
        pendAny = mPend || p;
        mPend   = pendAny;
        if (!t) return;
        green = (mPh == 0 || mPh == 3);
        if (mPh == 6) begin
            if (!n) enterPh(5);
            else    mBlink = !mBlink;
        end else if (green && n) begin
            enterPh(mPh + 1);
        end else if (mRem == 1) begin
            if ((mPh == 2 || mPh == 5) && n) enterPh(6);
            else                             enterPh((mPh + 1) % 6);
        end else if (green && mRem > T_PED && pendAny) begin
            mRem = T_PED;
        end else begin
            mRem = mRem - 1;
        end
    endtask

    task automatic checkModel(input string tag);
        logic [5:0] l;
        l = lightsOf(mPh, mBlink);
        vectors++;
        assert (phase === 3'(mPh)) else begin
            errs++; $error("FAIL %s phase: got %0d want %0d", tag, phase, mPh);
        end
        vectors++;
        assert (remain === CNT_W'(mRem)) else begin
            errs++; $error("FAIL %s remain: got %0d want %0d", tag, remain, mRem);
        end
        vectors++;
        assert (ns_light === l[5:3]) else begin
            errs++; $error("FAIL %s ns_light: got %b want %b", tag, ns_light, l[5:3]);
        end
        vectors++;
        assert (ew_light === l[2:0]) else begin
            errs++; $error("FAIL %s ew_light: got %b want %b", tag, ew_light, l[2:0]);
        end
    endtask

    task automatic expectPR(input string tag, input int p, input int r);
        vectors++;
        assert (phase === 3'(p) && remain === CNT_W'(r)) else begin
            errs++;
            $error("FAIL %s: got phase %0d remain %0d want phase %0d remain %0d",
                   tag, phase, remain, p, r);
        end
    endtask

    task automatic expectLights(input string tag, input logic [2:0] ns, input logic [2:0] ew);
        vectors++;
        assert (ns_light === ns && ew_light === ew) else begin
            errs++; $error("FAIL %s lights: got %b/%b want %b/%b", tag, ns_light, ew_light, ns, ew);
        end
    endtask

    task automatic expectPend(input string tag, input bit want);
        vectors++;
        assert (dut.cur.pedPend === want) else begin
            errs++; $error("FAIL %s ped_pend: got %b want %b", tag, dut.cur.pedPend, want);
        end
    endtask

    // One clock cycle: drive, clock, advance model, compare. night is a level.
    task automatic step(input bit r, input bit t, input bit n, input bit p, input string tag);
        rst = r; tick = t; night = n; ped_req = p;
        @(posedge clockIn);
        modelStep(r, t, n, p);
        #1;
        checkModel(tag);
        rst = 0; tick = 0; ped_req = 0;
    endtask

    task automatic runUntil(input int p, input int r, input string tag);
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            if (phase === 3'(p) && remain === CNT_W'(r)) begin
                found = 1;
                break;
            end
            step(0, 1, 0, 0, tag);
        end
        vectors++;
        assert (found) else begin
            errs++; $error("FAIL %s: never reached phase %0d remain %0d", tag, p, r);
        end
    endtask

    // Never two directions on green/yellow at once outside night; lights one-hot or off.
    always @(negedge clockIn) begin
        if (armed) begin
            vectors++;
            assert ((phase == 3'd6) || !((|ns_light[1:0]) && (|ew_light[1:0]))) else begin
                errs++; $error("FAIL conflict: ns %b ew %b phase %0d", ns_light, ew_light, phase);
            end
            vectors++;
            assert ($countones(ns_light) <= 1 && $countones(ew_light) <= 1) else begin
                errs++; $error("FAIL onehot: ns %b ew %b", ns_light, ew_light);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seqPh  [20] = '{0,0,0,0,1,1,2,3,3,3,3,4,4,5,0,0,0,0,1,1};
        int seqRem [20] = '{4,3,2,1,2,1,1,4,3,2,1,2,1,1,4,3,2,1,2,1};
        bit n;

        // reset state
        step(1, 0, 0, 0, "reset");
        armed = 1;
        expectPR("reset", 5, 1);
        expectLights("reset", 3'b100, 3'b100);
        expectPend("reset", 0);

        // normal ring with idle cycles between ticks
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, "idle");
            step(0, 1, 0, 0, "ring");
            expectPR($sformatf("ring%0d", i), seqPh[i], seqRem[i]);
        end

        // pedestrian request shortens green; second request cleared at RED1
        runUntil(0, 4, "toNSG");
        step(0, 0, 0, 1, "pedPulse");
        step(0, 1, 0, 0, "ped1");  expectPR("ped1", 0, 2);
        step(0, 1, 0, 0, "ped2");  expectPR("ped2", 0, 1);
        step(0, 1, 0, 0, "ped3");  expectPR("ped3", 1, 2);
        step(0, 0, 0, 1, "pedY");  expectPend("pedY", 1);
        step(0, 1, 0, 0, "ped4");  expectPR("ped4", 1, 1);
        step(0, 1, 0, 0, "ped5");  expectPR("ped5", 2, 1);
        expectPend("pedRed1", 0);
        step(0, 1, 0, 0, "ped6");  expectPR("ped6", 3, 4);
        step(0, 1, 0, 0, "ped7");  expectPR("ped7", 3, 3);

        // night request truncates EW green, yellow runs out, then blink
        step(0, 1, 1, 0, "n1");    expectPR("n1", 4, 2);
        step(0, 1, 1, 0, "n2");    expectPR("n2", 4, 1);
        step(0, 1, 1, 0, "n3");    expectPR("n3", 5, 1);
        step(0, 1, 1, 0, "n4");    expectPR("n4", 6, 0);
        expectLights("n4", 3'b010, 3'b010);
        step(0, 0, 1, 0, "nIdle"); expectLights("nIdle", 3'b010, 3'b010);
        step(0, 1, 1, 0, "n5");    expectLights("n5", 3'b000, 3'b000);
        step(0, 1, 1, 0, "n6");    expectLights("n6", 3'b010, 3'b010);
        expectPR("n6", 6, 0);

        // leaving night
        step(0, 1, 0, 0, "day1");  expectPR("day1", 5, 1);
        expectLights("day1", 3'b100, 3'b100);
        step(0, 1, 0, 0, "day2");  expectPR("day2", 0, 4);

        // reset coincident with tick in NS_Y
        runUntil(1, 2, "toNSY");
        step(0, 0, 0, 1, "pedBeforeRst");
        expectPend("pedBeforeRst", 1);
        step(1, 1, 0, 0, "rstTick");
        expectPR("rstTick", 5, 1);
        expectPend("rstTick", 0);

        // no tick: nothing may move
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "hold");
            expectPR("hold", 5, 1);
        end

        // randomized traffic
        n = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 4) n = !n;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, n,
                 $urandom_range(0, 9) == 0, "rand");
        end

        armed = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 SHALL have parameter T_GREEN, default 25: green phase length in ticks.
REQ-002 SHALL have parameter T_YELLOW, default 3: yellow phase length in ticks.
REQ-003 SHALL have parameter T_ALLRED, default 2: all-red clearance length in ticks.
REQ-004 SHALL have parameter T_PED, default 5: green remainder after a pedestrian request.
REQ-005 SHALL have parameter CNT_W, default 7: width of the countdown; all T_* values lie in 1..2^CNT_W-1, and T_PED < T_GREEN.
REQ-006 SHALL have port clockIn, input, 1 bit: single clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port tick, input, 1 bit: one-clockIn-cycle 1 Hz enable pulse from the frequency divider.
REQ-009 SHALL have port night, input, 1 bit: level request for flashing-yellow night mode.
REQ-010 SHALL have port ped_req, input, 1 bit: pedestrian button pulse, sampled every cycle.
REQ-011 SHALL have port ns_light, output, 3 bits: north-south {R,Y,G}, one-hot or 000.
REQ-012 SHALL have port ew_light, output, 3 bits: east-west {R,Y,G}, one-hot or 000.
REQ-013 SHALL have port remain, output, CNT_W bits: ticks left in current phase, for the 7-segment display.
REQ-014 SHALL have port phase, output, 3 bits: current state encoding, for debug.

Function
REQ-015 SHALL implement states NS_G(0), NS_Y(1), RED1(2), EW_G(3), EW_Y(4), RED2(5), NIGHT(6).
REQ-016 SHALL use the normal cycle NS_G -> NS_Y -> RED1 -> EW_G -> EW_Y -> RED2 -> NS_G.
REQ-017 SHALL drive lights as: NS_G ns=001 ew=100; NS_Y ns=010 ew=100; EW_G ns=100 ew=001; EW_Y ns=100 ew=010; RED1/RED2 both 100; NIGHT both = {0,blink,0}.
REQ-018 SHALL load remain with the new phase duration on entry to every phase, and decrement it only on cycles where tick=1.
REQ-019 SHALL change phase on a tick cycle with remain==1, so each phase lasts exactly its duration in ticks; nothing changes on cycles where tick=0.
REQ-020 SHALL latch ped_req into ped_pend and clear ped_pend on entry to RED1 or RED2.
REQ-021 SHALL, in NS_G or EW_G on a tick with remain > T_PED and (ped_pend or ped_req), load remain with T_PED instead of decrementing.
REQ-022 SHALL, on a tick in NS_G or EW_G with night=1, go directly to that direction's yellow; the green is truncated and yellow is never skipped.
REQ-023 SHALL, when a RED1 or RED2 phase expires with night=1, enter NIGHT instead of the next green.
REQ-024 SHALL let a yellow phase run its full duration regardless of night.
REQ-025 SHALL, in NIGHT, hold remain at 0 and toggle blink on every tick; blink=1 on entry.
REQ-026 SHALL, on a tick in NIGHT with night=0, enter RED2 with remain=T_ALLRED and then proceed normally.
REQ-027 SHALL never, in any state, assert green or yellow on both directions at once except NIGHT yellow.
REQ-028 SHALL treat an illegal phase encoding (7) as RED2 on the next cycle.

Reset
REQ-029 SHALL, on a clockIn edge with rst=1, set phase=RED2, remain=T_ALLRED, ns_light=ew_light=100, ped_pend=0, blink=0.
REQ-030 SHALL give rst priority over tick, night and ped_req, including mid-phase and in NIGHT.

Verification
(Bench parameters: T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_PED=2.)
REQ-031 SHALL cover reset then 20 ticks: phases RED2(1) -> NS_G(4,3,2,1) -> NS_Y(2,1) -> RED1(1) -> EW_G -> EW_Y -> RED2 -> NS_G, with remain values as listed.
REQ-032 SHALL cover ped_req pulsed in NS_G at remain=4: remain goes to 2 at the next tick, then 1, then NS_Y; a second ped_req in NS_Y has no effect and is cleared at RED1.
REQ-033 SHALL cover night=1 asserted in EW_G at remain=3: next tick EW_Y(2), EW_Y(1), RED2(1), then NIGHT with both lights toggling 010/000 each tick.
REQ-034 SHALL cover night dropped while in NIGHT: next tick RED2 with remain=1, lights 100/100, then NS_G with remain=4.
REQ-035 SHALL cover rst asserted in NS_Y coincident with tick: next state RED2, remain=1, ped_pend=0.
REQ-036 SHALL cover tick held low for 100 cycles: phase and remain remain constant; an assertion checks REQ-027 in every cycle.
